// File: rtl/risc16_pkg.sv
// Shared types for the RiSC-16 data-memory arbiter: port ids, arbiter states
// and the request payload forwarded to the RAM.
package risc16_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; bit 0 is the core port, bit 1 the loader port.
// The force inputs override the rotation while the loader holds a lock.
module rr_pick2
  import risc16_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last_winner,
  input  logic       force_d,
  input  logic       force_c,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
    if (force_c) begin
      gnt_c = {1'b0, req[0]};
    end else if (force_d) begin
      gnt_c = {req[1], 1'b0};
    end else if (req == 2'b11) begin
      gnt_c = (last_winner == PORT_D) ? 2'b01 : 2'b10;
    end else begin
      gnt_c = req;
    end
  end

endmodule

// File: rtl/risc16_dmem_arbiter.sv
// Shares the RiSC-16 single-port data RAM between the core (C) and the loader (D):
// round-robin, plus a D lock that yields one slot to a waiting core every p_MAX_LOCK grants.
module risc16_dmem_arbiter
  import risc16_pkg::*;
#(
  parameter int unsigned p_DATA_MEM_SIZE = 1024,
  parameter int unsigned p_ADDR_W        = $clog2(p_DATA_MEM_SIZE),
  parameter int unsigned p_MAX_LOCK      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [WORD_W-1:0]   c_addr,
  input  logic [WORD_W-1:0]   c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [WORD_W-1:0]   c_rdata,
  output logic                c_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_W-1:0]   d_addr,
  input  logic [WORD_W-1:0]   d_wdata,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_en,
  output logic                m_we,
  output logic [p_ADDR_W-1:0] m_addr,
  output logic [WORD_W-1:0]   m_wdata,
  input  logic [WORD_W-1:0]   m_rdata
);

  localparam int unsigned CNT_W = $clog2(p_MAX_LOCK + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  port_e            last_winner;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_hold;
  logic             lock_full;
  logic             force_c;
  logic             force_d;
  logic [1:0]       gnt;
  mem_req_t         c_bus;
  mem_req_t         d_bus;
  mem_req_t         win;
  logic             in_range;
  logic             cpl_c;
  logic             cpl_d;
  logic             cpl_err;
  logic             cpl_rd;

  assign c_bus = '{we: c_we, addr: c_addr, wdata: c_wdata};
  assign d_bus = '{we: d_we, addr: d_addr, wdata: d_wdata};

  // Lock holds only while D keeps both req and lock high; the core gets one slot when the count saturates.
  assign lock_hold = (state == LOCKED) && d_req && d_lock;
  assign lock_full = (lock_cnt == CNT_W'(p_MAX_LOCK));
  assign force_c   = lock_hold && lock_full && c_req;
  assign force_d   = lock_hold && !force_c;

  rr_pick2 u_pick (
    .req         ({d_req, c_req}),
    .last_winner (last_winner),
    .force_d     (force_d),
    .force_c     (force_c),
    .gnt_c       (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (gnt[1] && d_lock) state_nxt = LOCKED;
      LOCKED:  if (!lock_hold)       state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    c_gnt    = gnt[0];
    d_gnt    = gnt[1];
    win      = gnt[1] ? d_bus : c_bus;
    in_range = 32'(win.addr) < p_DATA_MEM_SIZE;
    m_en     = (|gnt) && in_range;
    m_we     = (|gnt) && win.we;
    m_addr   = in_range ? p_ADDR_W'(win.addr) : '0;
    m_wdata  = win.wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner <= PORT_D;
      lock_cnt    <= '0;
    end else begin
      if (gnt[0])      last_winner <= PORT_C;
      else if (gnt[1]) last_winner <= PORT_D;

      if (!lock_hold || force_c)  lock_cnt <= '0;
      else if (gnt[1] && c_req)   lock_cnt <= lock_cnt + CNT_W'(1);
    end
  end

  // One-cycle completion pipeline; reset drops any access still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpl_c   <= 1'b0;
      cpl_d   <= 1'b0;
      cpl_err <= 1'b0;
      cpl_rd  <= 1'b0;
    end else begin
      cpl_c   <= gnt[0];
      cpl_d   <= gnt[1];
      cpl_err <= (|gnt) && !in_range;
      cpl_rd  <= (|gnt) && in_range && !win.we;
    end
  end

  assign c_rvalid = cpl_c;
  assign c_err    = cpl_c && cpl_err;
  assign c_rdata  = (cpl_c && cpl_rd) ? m_rdata : '0;
  assign d_rvalid = cpl_d;
  assign d_err    = cpl_d && cpl_err;
  assign d_rdata  = (cpl_d && cpl_rd) ? m_rdata : '0;

endmodule

// File: tb/tb_risc16_dmem_arbiter.sv
// Randomized bench for risc16_dmem_arbiter: queue-driven requesters, a RAM with
// 1-cycle read latency, and a cycle-level reference model of the arbitration rules.
module tb_risc16_dmem_arbiter;

  localparam int unsigned MEM  = 1024;
  localparam int          MAXL = 8;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        c_gnt;
    logic        d_gnt;
    logic        m_en;
    logic        c_rvalid;
    logic        c_err;
    logic [15:0] c_rdata;
    logic        d_rvalid;
    logic        d_err;
    logic [15:0] d_rdata;
  } obs_t;

  logic        clk, rst;
  logic        c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [15:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;

  logic [15:0] ram     [MEM];
  logic [15:0] ref_mem [MEM];
  txn_t        cq[$];
  txn_t        dq[$];
  bit          c_hold, d_hold;
  int unsigned gap_c, gap_d;
  bit          mdl_locked, mdl_last_d;
  int          mdl_cnt;
  bit          pc_v, pc_err, pd_v, pd_err;
  logic [15:0] pc_rd, pd_rd;
  int          total, bad;

  risc16_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] seed_word(int i);
    return 16'((i * 40503) ^ 'h5a5a);
  endfunction

  // Synchronous single-port RAM behind the arbiter
  initial begin
    for (int i = 0; i < MEM; i++) ram[i] = seed_word(i);
    m_rdata = '0;
    forever begin
      @(posedge clk);
      if (m_en) begin
        if (m_we) ram[m_addr] <= m_wdata;
        else      m_rdata     <= ram[m_addr];
      end
    end
  end

  function automatic txn_t mk(logic we, logic lock, logic [15:0] addr, logic [15:0] wdata);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic obs_t sample();
    return {c_gnt, d_gnt, m_en, c_rvalid, c_err, c_rdata, d_rvalid, d_err, d_rdata};
  endfunction

  task automatic model_reset();
    mdl_locked = 0; mdl_last_d = 1; mdl_cnt = 0;
    pc_v = 0; pc_err = 0; pd_v = 0; pd_err = 0; pc_rd = '0; pd_rd = '0;
    cq.delete(); dq.delete(); c_hold = 0; d_hold = 0;
  endtask

  // Requesters keep req and payload stable until granted.
  task automatic drive();
    if (!c_hold && cq.size() > 0 && $urandom_range(99) >= gap_c) c_hold = 1;
    if (!d_hold && dq.size() > 0 && $urandom_range(99) >= gap_d) d_hold = 1;
    c_req = c_hold; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = d_hold; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    if (c_hold) begin
      c_we = cq[0].we; c_addr = cq[0].addr; c_wdata = cq[0].wdata;
    end
    if (d_hold) begin
      d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata; d_lock = dq[0].lock;
    end
  endtask

  // One clock: drive, sample at negedge, predict from the arbitration rules, advance the model.
  task automatic run_cycle(output obs_t o, output obs_t e);
    bit          hold, win_c, win_d, inr;
    txn_t        t;
    logic [15:0] rd;
    drive();
    @(negedge clk);
    o = sample();
    e = '0;
    e.c_rvalid = pc_v; e.c_err = pc_err; e.c_rdata = pc_rd;
    e.d_rvalid = pd_v; e.d_err = pd_err; e.d_rdata = pd_rd;
    hold = mdl_locked && d_req && d_lock;
    if (hold) begin
      win_c = c_req && (mdl_cnt == MAXL);
      win_d = !win_c;
    end else if (c_req && d_req) begin
      win_c = mdl_last_d;
      win_d = !mdl_last_d;
    end else begin
      win_c = c_req;
      win_d = d_req;
    end
    e.c_gnt = win_c; e.d_gnt = win_d;
    pc_v = win_c; pd_v = win_d; pc_err = 0; pd_err = 0; pc_rd = '0; pd_rd = '0;
    if (win_c || win_d) begin
      t = win_d ? dq[0] : cq[0];
      inr = (t.addr < 16'(MEM));
      e.m_en = inr;
      rd = '0;
      if (inr && !t.we) rd = ref_mem[t.addr[9:0]];
      if (inr && t.we)  ref_mem[t.addr[9:0]] = t.wdata;
      if (win_c) begin
        pc_err = !inr; pc_rd = rd; void'(cq.pop_front()); c_hold = 0;
      end else begin
        pd_err = !inr; pd_rd = rd; void'(dq.pop_front()); d_hold = 0;
      end
      mdl_last_d = win_d;
    end
    if (hold) begin
      if (win_c)      mdl_cnt = 0;
      else if (c_req) mdl_cnt++;
    end else begin
      mdl_cnt = 0;
    end
    mdl_locked = hold || (win_d && d_lock);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = sample();
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_outputs obs=%h exp=0", o); end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) begin
      run_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_idle obs=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid_read();
    obs_t o, e;
    gap_c = 0;
    cq.push_back(mk(1'b0, 1'b0, 16'd5, 16'd0));
    drive();
    @(negedge clk);
    total++;
    if (c_gnt !== 1'b1 || m_en !== 1'b1) begin
      bad++; $display("FAIL rmr_grant c_gnt=%b m_en=%b exp=1,1", c_gnt, m_en);
    end
    rst = 1'b0;
    #1;
    model_reset();
    drive();
    #1;
    o = sample();
    total++;
    if (o !== '0) begin bad++; $display("FAIL rmr_in_reset obs=%h exp=0", o); end
    @(posedge clk); #1;
    o = sample();
    total++;
    if (o !== '0) begin bad++; $display("FAIL rmr_after_edge obs=%h exp=0", o); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      run_cycle(o, e);
      total++;
      if (o !== e || o.c_rvalid !== 1'b0) begin
        bad++; $display("FAIL rmr_no_rvalid obs=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_tie();
    obs_t        o, e;
    obs_t        hist [8];
    logic [15:0] exp3;
    exp3 = ref_mem[3];
    gap_c = 0; gap_d = 0;
    cq.push_back(mk(1'b0, 1'b0, 16'd3, 16'd0));
    cq.push_back(mk(1'b0, 1'b0, 16'd4, 16'd0));
    dq.push_back(mk(1'b1, 1'b0, 16'd4, 16'hBEEF));
    for (int n = 0; n < 8; n++) begin
      run_cycle(o, e);
      hist[n] = o;
      total++;
      if (o !== e) begin bad++; $display("FAIL tie_cycle%0d obs=%h exp=%h", n, o, e); end
    end
    total++;
    if (hist[0].c_gnt !== 1'b1 || hist[0].d_gnt !== 1'b0) begin
      bad++; $display("FAIL tie_c_first c=%b d=%b exp=1,0", hist[0].c_gnt, hist[0].d_gnt);
    end
    total++;
    if (hist[1].d_gnt !== 1'b1 || hist[1].c_rvalid !== 1'b1 || hist[1].c_rdata !== exp3) begin
      bad++; $display("FAIL tie_c_done d_gnt=%b rv=%b rdata=%h exp=1,1,%h",
                      hist[1].d_gnt, hist[1].c_rvalid, hist[1].c_rdata, exp3);
    end
    total++;
    if (hist[2].d_rvalid !== 1'b1 || hist[2].d_rdata !== 16'h0) begin
      bad++; $display("FAIL tie_d_done rv=%b rdata=%h exp=1,0000", hist[2].d_rvalid, hist[2].d_rdata);
    end
    total++;
    if (hist[3].c_rvalid !== 1'b1 || hist[3].c_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL tie_readback rv=%b rdata=%h exp=1,beef", hist[3].c_rvalid, hist[3].c_rdata);
    end
  endtask

  task automatic test_contention();
    obs_t o, e;
    bit   first_c, exp_c;
    gap_c = 0; gap_d = 0;
    first_c = 0;
    for (int i = 0; i < 16; i++) begin
      cq.push_back(mk(1'($urandom_range(1)), 1'b0, 16'($urandom_range(MEM - 1)), 16'($urandom)));
      dq.push_back(mk(1'($urandom_range(1)), 1'b0, 16'($urandom_range(MEM - 1)), 16'($urandom)));
    end
    for (int n = 0; n < 32; n++) begin
      run_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL contention_model obs=%h exp=%h", o, e); end
      total++;
      if ((o.c_gnt ^ o.d_gnt) !== 1'b1) begin
        bad++; $display("FAIL contention_one_grant c=%b d=%b exp one", o.c_gnt, o.d_gnt);
      end
      if (n == 0) begin
        first_c = o.c_gnt;
      end else begin
        exp_c = ((n % 2) == 1) ? !first_c : first_c;
        total++;
        if (o.c_gnt !== exp_c) begin
          bad++; $display("FAIL contention_alternate cycle=%0d c=%b exp=%b", n, o.c_gnt, exp_c);
        end
      end
    end
    for (int n = 0; n < 2; n++) begin
      run_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL contention_drain obs=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_lock_fairness();
    obs_t        o, e;
    logic [15:0] wd [20];
    int          stall, max_stall, n, errs;
    gap_c = 0; gap_d = 0;
    stall = 0; max_stall = 0; n = 0; errs = 0;
    for (int i = 0; i < 20; i++) begin
      wd[i] = 16'($urandom);
      dq.push_back(mk(1'b1, 1'b1, 16'(i), wd[i]));
    end
    for (int i = 0; i < 40; i++) cq.push_back(mk(1'b0, 1'b0, 16'(100 + i), 16'd0));
    while (dq.size() > 0 && n < 200) begin
      run_cycle(o, e);
      n++;
      total++;
      if (o !== e) begin bad++; $display("FAIL lock_fair_model obs=%h exp=%h", o, e); end
      if (c_req && !o.c_gnt) stall++;
      else                   stall = 0;
      if (stall > max_stall) max_stall = stall;
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL lock_fair_timeout cycles=%0d exp<200", n); end
    total++;
    if (max_stall != MAXL + 1) begin
      bad++; $display("FAIL lock_fair_wait max_wait=%0d exp=%0d", max_stall, MAXL + 1);
    end
    n = 0;
    while (cq.size() > 0 && n < 200) begin
      run_cycle(o, e);
      n++;
      total++;
      if (o !== e) begin bad++; $display("FAIL lock_fair_drain obs=%h exp=%h", o, e); end
    end
    run_cycle(o, e);
    total++;
    if (o !== e || n >= 200) begin bad++; $display("FAIL lock_fair_tail obs=%h exp=%h", o, e); end
    for (int i = 0; i < 20; i++) if (ram[i] !== wd[i]) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL lock_fair_ram wrong_words=%0d exp=0", errs); end
  endtask

  task automatic test_lock_idle();
    obs_t o, e;
    int   dg, before_c, n;
    bit   seen_c;
    gap_c = 0; gap_d = 0;
    dg = 0; before_c = 0; n = 0; seen_c = 0;
    for (int i = 0; i < 20; i++) dq.push_back(mk(1'b1, 1'b1, 16'(200 + i), 16'($urandom)));
    for (int k = 0; k < 20; k++) begin
      run_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL lock_idle_model obs=%h exp=%h", o, e); end
      if (o.d_gnt === 1'b1) dg++;
    end
    total++;
    if (dg != 20) begin bad++; $display("FAIL lock_idle_burst d_grants=%0d exp=20", dg); end
    // Core joins the still-locked burst: count must start from zero.
    for (int i = 0; i < 12; i++) dq.push_back(mk(1'b1, 1'b1, 16'(300 + i), 16'($urandom)));
    for (int i = 0; i < 4; i++)  cq.push_back(mk(1'b0, 1'b0, 16'(300 + i), 16'd0));
    while ((cq.size() > 0 || dq.size() > 0) && n < 100) begin
      run_cycle(o, e);
      n++;
      total++;
      if (o !== e) begin bad++; $display("FAIL lock_idle_join obs=%h exp=%h", o, e); end
      if (!seen_c) begin
        if (o.c_gnt === 1'b1)      seen_c = 1;
        else if (o.d_gnt === 1'b1) before_c++;
      end
    end
    run_cycle(o, e);
    total++;
    if (o !== e || n >= 100) begin bad++; $display("FAIL lock_idle_tail obs=%h exp=%h", o, e); end
    total++;
    if (before_c != MAXL) begin
      bad++; $display("FAIL lock_idle_count d_before_c=%0d exp=%0d", before_c, MAXL);
    end
  endtask

  task automatic test_out_of_range();
    obs_t        o, e;
    obs_t        hist [3];
    logic [15:0] snap;
    snap = ram[2000 % MEM];
    gap_c = 0; gap_d = 0;
    cq.push_back(mk(1'b0, 1'b0, 16'd1024, 16'd0));
    for (int n = 0; n < 3; n++) begin
      run_cycle(o, e);
      hist[n] = o;
      total++;
      if (o !== e) begin bad++; $display("FAIL oor_c_model obs=%h exp=%h", o, e); end
    end
    total++;
    if (hist[0].c_gnt !== 1'b1 || hist[0].m_en !== 1'b0) begin
      bad++; $display("FAIL oor_c_grant gnt=%b m_en=%b exp=1,0", hist[0].c_gnt, hist[0].m_en);
    end
    total++;
    if (hist[1].c_rvalid !== 1'b1 || hist[1].c_err !== 1'b1 || hist[1].c_rdata !== 16'h0) begin
      bad++; $display("FAIL oor_c_err rv=%b err=%b rdata=%h exp=1,1,0000",
                      hist[1].c_rvalid, hist[1].c_err, hist[1].c_rdata);
    end
    dq.push_back(mk(1'b1, 1'b0, 16'd2000, 16'h1234));
    for (int n = 0; n < 3; n++) begin
      run_cycle(o, e);
      hist[n] = o;
      total++;
      if (o !== e) begin bad++; $display("FAIL oor_d_model obs=%h exp=%h", o, e); end
    end
    total++;
    if (hist[0].d_gnt !== 1'b1 || hist[0].m_en !== 1'b0) begin
      bad++; $display("FAIL oor_d_grant gnt=%b m_en=%b exp=1,0", hist[0].d_gnt, hist[0].m_en);
    end
    total++;
    if (hist[1].d_rvalid !== 1'b1 || hist[1].d_err !== 1'b1 || hist[1].c_err !== 1'b0) begin
      bad++; $display("FAIL oor_d_err rv=%b err=%b c_err=%b exp=1,1,0",
                      hist[1].d_rvalid, hist[1].d_err, hist[1].c_err);
    end
    total++;
    if (ram[2000 % MEM] !== snap) begin
      bad++; $display("FAIL oor_ram_alias got=%h exp=%h", ram[2000 % MEM], snap);
    end
  endtask

  task automatic test_random();
    obs_t        o, e;
    int          n;
    logic [15:0] a;
    gap_c = 30; gap_d = 30; n = 0;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(MEM - 1));
      cq.push_back(mk(1'($urandom_range(1)), 1'b0, a, 16'($urandom)));
      a = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(MEM - 1));
      dq.push_back(mk(1'($urandom_range(1)), ($urandom_range(2) == 0), a, 16'($urandom)));
    end
    while ((cq.size() > 0 || dq.size() > 0) && n < 2000) begin
      run_cycle(o, e);
      n++;
      total++;
      if (o !== e) begin bad++; $display("FAIL random_model cycle=%0d obs=%h exp=%h", n, o, e); end
    end
    run_cycle(o, e);
    total++;
    if (o !== e || n >= 2000) begin bad++; $display("FAIL random_tail cycles=%0d obs=%h exp=%h", n, o, e); end
  endtask

  task automatic test_final_ram();
    int errs;
    errs = 0;
    for (int i = 0; i < MEM; i++) if (ram[i] !== ref_mem[i]) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL final_ram wrong_words=%0d exp=0", errs); end
  endtask

  initial begin
    total = 0; bad = 0;
    gap_c = 0; gap_d = 0;
    rst = 1'b0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = seed_word(i);
    model_reset();
    drive();
    test_reset();
    test_reset_mid_read();
    test_tie();
    test_contention();
    test_lock_fairness();
    test_lock_idle();
    test_out_of_range();
    test_random();
    test_final_ram();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
